// File: rtl/bias_act_requant_pkg.sv
// Shared types for the post-MVM bias/activation/requantisation stage.
// Holds the state encoding and default geometry used by the top and its element datapath.
package bias_act_requant_pkg;

    localparam int DEF_ROWS      = 6;
    localparam int DEF_IN_WIDTH  = 16;
    localparam int DEF_OUT_WIDTH = 8;
    localparam int DEF_SHIFT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PROCESS = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // Index counter width; at least one bit so a single-row vector still has a counter.
    function automatic int idx_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/bias_act_requant_elem.sv
// One element of the requantiser: bias add, arithmetic right shift, optional ReLU, saturate.
// Purely combinational; the top feeds it the element selected by its index counter.
module requant_elem #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT_W   = 4
) (
    input  logic signed [IN_WIDTH-1:0]  in_elem,
    input  logic signed [IN_WIDTH-1:0]  bias_elem,
    input  logic        [SHIFT_W-1:0]   shift,
    input  logic                        relu_en,
    output logic signed [OUT_WIDTH-1:0] out_elem
);

    // One extra bit on the sum so the bias add can never wrap.
    localparam int SUM_W = IN_WIDTH + 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] shifted;
    int                      shamt;

    always_comb begin
        sum = $signed({in_elem[IN_WIDTH-1], in_elem}) + $signed({bias_elem[IN_WIDTH-1], bias_elem});

        // Shifts at or beyond the input width collapse to a full sign fill.
        shamt = int'(shift);
        if (shamt >= IN_WIDTH) begin
            shamt = IN_WIDTH;
        end

        shifted = sum >>> shamt;
        if (relu_en && shifted[SUM_W-1]) begin
            shifted = '0;
        end

        if (shifted > SAT_MAX) begin
            out_elem = SAT_MAX[OUT_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            out_elem = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            out_elem = shifted[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/bias_act_requant.sv
// Post-MVM stage: captures an accumulator vector on start, requantises one element per cycle,
// then publishes the whole result vector at once with a one-cycle done pulse.
module bias_act_requant
    import bias_act_requant_pkg::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int SHIFT_W   = DEF_SHIFT_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [ROWS*IN_WIDTH-1:0]  in_vector,
    input  logic [ROWS*IN_WIDTH-1:0]  bias,
    input  logic [SHIFT_W-1:0]        shift,
    input  logic                      relu_en,
    output logic [ROWS*OUT_WIDTH-1:0] out_vector,
    output logic                      busy,
    output logic                      done,
    output state_e                    dbg_state
);

    localparam int               IDX_W    = idx_width(ROWS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROWS - 1);

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [ROWS*IN_WIDTH-1:0]  in_q, in_d;
    logic [ROWS*IN_WIDTH-1:0]  bias_q, bias_d;
    logic [SHIFT_W-1:0]        shift_q, shift_d;
    logic                      relu_q, relu_d;
    logic signed [OUT_WIDTH-1:0] work_q [ROWS];
    logic signed [OUT_WIDTH-1:0] work_d [ROWS];
    logic [ROWS*OUT_WIDTH-1:0] out_q, out_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic signed [IN_WIDTH-1:0]  in_arr   [ROWS];
    logic signed [IN_WIDTH-1:0]  bias_arr [ROWS];
    logic signed [IN_WIDTH-1:0]  in_sel;
    logic signed [IN_WIDTH-1:0]  bias_sel;
    logic signed [OUT_WIDTH-1:0] elem_res;

    // Element 0 lives in the MSBs, matching the upstream row order.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            in_arr[i]   = in_q[(ROWS-1-i)*IN_WIDTH +: IN_WIDTH];
            bias_arr[i] = bias_q[(ROWS-1-i)*IN_WIDTH +: IN_WIDTH];
        end
        in_sel   = in_arr[idx_q];
        bias_sel = bias_arr[idx_q];
    end

    requant_elem #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT_W   (SHIFT_W)
    ) u_elem (
        .in_elem   (in_sel),
        .bias_elem (bias_sel),
        .shift     (shift_q),
        .relu_en   (relu_q),
        .out_elem  (elem_res)
    );

    // Handshake: start is a level sampled only in IDLE; done is a one-cycle pulse and
    // out_vector is stable from that cycle until the next done. busy covers the run in between.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        in_d    = in_q;
        bias_d  = bias_q;
        shift_d = shift_q;
        relu_d  = relu_q;
        work_d  = work_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    in_d    = in_vector;
                    bias_d  = bias;
                    shift_d = shift;
                    relu_d  = relu_en;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_PROCESS;
                end
            end
            ST_PROCESS: begin
                work_d[idx_q] = elem_res;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                for (int i = 0; i < ROWS; i++) begin
                    out_d[(ROWS-1-i)*OUT_WIDTH +: OUT_WIDTH] = work_q[i];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            in_q    <= '0;
            bias_q  <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                work_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            in_q    <= in_d;
            bias_q  <= bias_d;
            shift_q <= shift_d;
            relu_q  <= relu_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int i = 0; i < ROWS; i++) begin
                work_q[i] <= work_d[i];
            end
        end
    end

    assign out_vector = out_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_bias_act_requant.sv
// Directed bench for bias_act_requant: reset, arithmetic corners, handshake, back-to-back and abort.
`timescale 1ns/1ps
module tb_bias_act_requant;
    import bias_act_requant_pkg::*;

    localparam int ROWS     = 6;
    localparam int IN_W     = 16;
    localparam int OUT_W    = 8;
    localparam int SH_W     = 4;
    localparam int LAT      = ROWS + 1;
    localparam int MAX_WAIT = 40;

    logic                   clk       = 1'b0;
    logic                   reset_n   = 1'b0;
    logic                   start     = 1'b0;
    logic                   relu_en   = 1'b0;
    logic [ROWS*IN_W-1:0]   in_vector = '0;
    logic [ROWS*IN_W-1:0]   bias      = '0;
    logic [SH_W-1:0]        shift     = '0;
    logic [ROWS*OUT_W-1:0]  out_vector;
    logic                   busy;
    logic                   done;
    state_e                 dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bias_act_requant #(
        .ROWS      (ROWS),
        .IN_WIDTH  (IN_W),
        .OUT_WIDTH (OUT_W),
        .SHIFT_W   (SH_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .in_vector  (in_vector),
        .bias       (bias),
        .shift      (shift),
        .relu_en    (relu_en),
        .out_vector (out_vector),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    function automatic logic [ROWS*IN_W-1:0] pk_in(input int e0, e1, e2, e3, e4, e5);
        return {IN_W'(e0), IN_W'(e1), IN_W'(e2), IN_W'(e3), IN_W'(e4), IN_W'(e5)};
    endfunction

    function automatic logic [ROWS*OUT_W-1:0] pk_out(input int e0, e1, e2, e3, e4, e5);
        return {OUT_W'(e0), OUT_W'(e1), OUT_W'(e2), OUT_W'(e3), OUT_W'(e4), OUT_W'(e5)};
    endfunction

    // Drive one start pulse; returns #1 after the edge that samples it.
    task automatic drive_start(input logic [ROWS*IN_W-1:0] iv, input logic [ROWS*IN_W-1:0] bv,
                               input logic [SH_W-1:0] sh, input logic r);
        in_vector = iv;
        bias      = bv;
        shift     = sh;
        relu_en   = r;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Cycles until done is seen, or -1 if the budget runs out.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= MAX_WAIT; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat;
        reset_n = 1'b0;
        start   = 1'b1;
        in_vector = pk_in(1, 2, 3, 4, 5, 6);
        bias    = '0;
        shift   = '0;
        relu_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_vector !== '0) begin n_fail++; $display("FAIL reset_out: got %h expected 0", out_vector); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_first_accept: busy got %b expected 1", busy); end
        wait_done(lat);
        n_checks++;
        if (lat !== LAT) begin n_fail++; $display("FAIL reset_first_latency: got %0d expected %0d", lat, LAT); end
        n_checks++;
        if (out_vector !== pk_out(1, 2, 3, 4, 5, 6)) begin
            n_fail++; $display("FAIL reset_first_out: got %h expected %h", out_vector, pk_out(1, 2, 3, 4, 5, 6));
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [ROWS*OUT_W-1:0] exp_v;
        exp_v = pk_out(100, 0, 127, 0, 5, 0);
        drive_start(pk_in(100, -50, 300, 0, 5, -1), '0, 4'd0, 1'b1);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL basic_busy: busy/done got %b/%b expected 1/0", busy, done);
        end
        wait_done(lat);
        n_checks++;
        if (lat !== LAT) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT); end
        n_checks++;
        if (out_vector !== exp_v) begin n_fail++; $display("FAIL basic_out: got %h expected %h", out_vector, exp_v); end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_pulse: done/busy got %b/%b expected 0/0", done, busy);
        end
        n_checks++;
        if (out_vector !== exp_v) begin n_fail++; $display("FAIL basic_hold: got %h expected %h", out_vector, exp_v); end
    endtask

    task automatic test_shift_bias();
        int lat;
        logic [ROWS*OUT_W-1:0] exp_v;
        exp_v = pk_out(-64, 64, 2, -2, 127, -128);
        drive_start(pk_in(-300, 256, 7, -8, 1000, -1000), pk_in(44, 0, 1, 0, 24, -24), 4'd2, 1'b0);
        wait_done(lat);
        n_checks++;
        if (lat !== LAT) begin n_fail++; $display("FAIL shift_bias_latency: got %0d expected %0d", lat, LAT); end
        n_checks++;
        if (out_vector !== exp_v) begin n_fail++; $display("FAIL shift_bias_out: got %h expected %h", out_vector, exp_v); end
    endtask

    task automatic test_extremes();
        int lat;
        logic [ROWS*OUT_W-1:0] exp_v;
        exp_v = pk_out(127, 127, 127, 127, 127, 127);
        drive_start(pk_in(32767, 32767, 32767, 32767, 32767, 32767),
                    pk_in(32767, 32767, 32767, 32767, 32767, 32767), 4'd0, 1'b0);
        wait_done(lat);
        n_checks++;
        if (lat !== LAT || out_vector !== exp_v) begin
            n_fail++; $display("FAIL extreme_pos: lat %0d out %h expected lat %0d out %h", lat, out_vector, LAT, exp_v);
        end
        exp_v = pk_out(-128, -128, -128, -128, -128, -128);
        drive_start(pk_in(-32768, -32768, -32768, -32768, -32768, -32768),
                    pk_in(-32768, -32768, -32768, -32768, -32768, -32768), 4'd0, 1'b0);
        wait_done(lat);
        n_checks++;
        if (lat !== LAT || out_vector !== exp_v) begin
            n_fail++; $display("FAIL extreme_neg: lat %0d out %h expected lat %0d out %h", lat, out_vector, LAT, exp_v);
        end
        exp_v = pk_out(-1, 0, -1, 0, -1, 0);
        drive_start(pk_in(-1, 32767, -32768, 1000, -1000, 0), '0, 4'd15, 1'b0);
        wait_done(lat);
        n_checks++;
        if (lat !== LAT || out_vector !== exp_v) begin
            n_fail++; $display("FAIL extreme_shift15: lat %0d out %h expected lat %0d out %h", lat, out_vector, LAT, exp_v);
        end
    endtask

    task automatic test_handshake();
        int lat;
        int extra;
        logic [ROWS*OUT_W-1:0] exp_v;
        exp_v = pk_out(-3, -1, 25, -65, 64, 127);
        drive_start(pk_in(-5, -1, 50, -129, 127, 32767), pk_in(0, 0, 0, 0, 1, 0), 4'd1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        in_vector = pk_in(9, 9, 9, 9, 9, 9);
        bias      = pk_in(1, 1, 1, 1, 1, 1);
        shift     = 4'd0;
        relu_en   = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        n_checks++;
        if (lat !== LAT - 3) begin n_fail++; $display("FAIL handshake_latency: got %0d expected %0d", lat, LAT - 3); end
        n_checks++;
        if (out_vector !== exp_v) begin n_fail++; $display("FAIL handshake_out: got %h expected %h", out_vector, exp_v); end
        extra = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) extra++;
        end
        n_checks++;
        if (extra !== 0) begin n_fail++; $display("FAIL handshake_single_done: extra dones %0d expected 0", extra); end
        n_checks++;
        if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL handshake_idle: state %0d expected %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [ROWS*OUT_W-1:0] exp_a;
        logic [ROWS*OUT_W-1:0] exp_b;
        exp_a = pk_out(-64, 64, 2, -2, 127, -128);
        exp_b = pk_out(100, 0, 127, 0, 5, 0);
        in_vector = pk_in(-300, 256, 7, -8, 1000, -1000);
        bias      = pk_in(44, 0, 1, 0, 24, -24);
        shift     = 4'd2;
        relu_en   = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        in_vector = pk_in(100, -50, 300, 0, 5, -1);
        bias      = '0;
        shift     = 4'd0;
        relu_en   = 1'b1;
        wait_done(lat);
        n_checks++;
        if (lat !== LAT || out_vector !== exp_a) begin
            n_fail++; $display("FAIL b2b_first: lat %0d out %h expected lat %0d out %h", lat, out_vector, LAT, exp_a);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_no_gap: busy got %b expected 1", busy); end
        wait_done(lat);
        n_checks++;
        if (lat !== LAT || out_vector !== exp_b) begin
            n_fail++; $display("FAIL b2b_second: lat %0d out %h expected lat %0d out %h", lat, out_vector, LAT, exp_b);
        end
    endtask

    task automatic test_abort();
        int lat;
        int seen;
        logic [ROWS*OUT_W-1:0] exp_v;
        exp_v = pk_out(100, 0, 127, 0, 5, 0);
        drive_start(pk_in(-300, 256, 7, -8, 1000, -1000), pk_in(44, 0, 1, 0, 24, -24), 4'd2, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_vector !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_clear: out %h busy %b done %b expected 0/0/0", out_vector, busy, done);
        end
        n_checks++;
        if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL abort_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        seen = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        reset_n = 1'b1;
        repeat (ROWS + 3) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done: dones %0d expected 0", seen); end
        drive_start(pk_in(100, -50, 300, 0, 5, -1), '0, 4'd0, 1'b1);
        wait_done(lat);
        n_checks++;
        if (lat !== LAT || out_vector !== exp_v) begin
            n_fail++; $display("FAIL abort_recover: lat %0d out %h expected lat %0d out %h", lat, out_vector, LAT, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shift_bias();
        test_extremes();
        test_handshake();
        test_back_to_back();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
